// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch front-end.
// Issues one read per cycle to a one-cycle-latency instruction memory while
// the FIFO has room. Returned words are stored with their PC and presented
// to decode via valid/ready. A redirect flushes the queue and any in-flight
// read, then restarts fetch at the new (word-aligned) PC.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] inst_mem_q [DEPTH];

  logic            pop_s;
  logic            push_s;
  logic            issue_s;
  logic            not_empty_s;
  logic [CW:0]     occ_s;

  // Handshake decode: pop, push and the space check that gates issue.
  // A pop in the same cycle frees a slot, which sustains one fetch per cycle.
  always_comb begin
    not_empty_s = (count_q != {CW{1'b0}});
    pop_s       = not_empty_s & inst_ready & ~redirect;
    push_s      = inflight_q & ~redirect;
    occ_s       = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop_s);
    issue_s     = ~rst & ~redirect & (occ_s < DEPTH_W);
  end

  // Next-state for fetch PC, in-flight tag and FIFO bookkeeping; redirect wins.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      inflight_d = 1'b0;
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      // Without redirect an outstanding read always completes this cycle,
      // so inflight simply follows whether a new read goes out.
      inflight_d = issue_s;
      if (issue_s) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_STEP;
      end else begin
        inflight_pc_d = inflight_pc_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= {XLEN{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage: capture {pc, word} at the tail when a response is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= {XLEN{1'b0}};
        inst_mem_q[i] <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Output drive: head entry, zeroed while the queue is empty.
  always_comb begin
    imem_req   = issue_s;
    imem_addr  = fetch_pc_q;
    inst_valid = not_empty_s;
    if (not_empty_s) begin
      inst    = inst_mem_q[rd_ptr_q];
      inst_pc = pc_mem_q[rd_ptr_q];
    end else begin
      inst    = {XLEN{1'b0}};
      inst_pc = {XLEN{1'b0}};
    end
  end

endmodule
